// File: rtl/demux_pkg.sv
// Shared definitions for the demux lane scheduler: lane-selection modes,
// skid FSM state encoding and default widths.
package demux_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic [1:0] MODE_ALT   = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_ROUTE = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/lane_counter.sv
// Wrapping per-lane delivery counter with synchronous reset and increment enable.
module lane_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/demux_lane_sched.sv
// Lane scheduler for the 1x2 demux: picks an output lane per word, parks a
// blocked word in a one-entry skid register and back-pressures upstream.
module demux_lane_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic [1:0]        mode,
    input  logic              full0,
    input  logic              full1,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    output logic              sel,
    output logic              stall,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ptr_q, ptr_d;
    logic [DATA_W-1:0] dataOut0_q, dataOut0_d;
    logic [DATA_W-1:0] dataOut1_q, dataOut1_d;
    logic              validOut0_q, validOut0_d;
    logic              validOut1_q, validOut1_d;
    logic              sel_q, sel_d;

    logic [1:0]        fullVec;
    logic              candValid;
    logic [DATA_W-1:0] candData;
    logic              tgt;
    logic              go;
    logic              deliver;

    assign fullVec   = {full1, full0};
    assign candValid = (state_q == ST_HOLD) | valid_in;
    assign candData  = (state_q == ST_HOLD) ? skid_q : data_in;

    // Lane choice; reserved mode 2'b11 falls through to ALT behaviour.
    always_comb begin
        tgt = ptr_q;
        go  = 1'b0;
        case (mode)
            MODE_RR: begin
                if (!fullVec[ptr_q]) begin
                    go = 1'b1;
                end else if (!fullVec[~ptr_q]) begin
                    tgt = ~ptr_q;
                    go  = 1'b1;
                end
            end
            MODE_ROUTE: begin
                tgt = candData[DATA_W-1];
                go  = !fullVec[candData[DATA_W-1]];
            end
            default: begin
                go = !fullVec[ptr_q];
            end
        endcase
    end

    assign deliver = candValid & go;

    always_comb begin
        state_d     = state_q;
        skid_d      = skid_q;
        ptr_d       = ptr_q;
        dataOut0_d  = dataOut0_q;
        dataOut1_d  = dataOut1_q;
        validOut0_d = 1'b0;
        validOut1_d = 1'b0;
        sel_d       = sel_q;
        if (deliver) begin
            sel_d = tgt;
            if (mode != MODE_ROUTE) begin
                ptr_d = ~tgt;
            end
            if (tgt) begin
                dataOut1_d  = candData;
                validOut1_d = 1'b1;
            end else begin
                dataOut0_d  = candData;
                validOut0_d = 1'b1;
            end
        end
        case (state_q)
            ST_EMPTY: begin
                if (candValid && !go) begin
                    skid_d  = candData;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (go) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            skid_q      <= '0;
            ptr_q       <= 1'b0;
            dataOut0_q  <= '0;
            dataOut1_q  <= '0;
            validOut0_q <= 1'b0;
            validOut1_q <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skid_q      <= skid_d;
            ptr_q       <= ptr_d;
            dataOut0_q  <= dataOut0_d;
            dataOut1_q  <= dataOut1_d;
            validOut0_q <= validOut0_d;
            validOut1_q <= validOut1_d;
            sel_q       <= sel_d;
        end
    end

    lane_counter #(.CNT_W(CNT_W)) uCnt0 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (deliver & ~tgt),
        .count_o (cnt0)
    );

    lane_counter #(.CNT_W(CNT_W)) uCnt1 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (deliver & tgt),
        .count_o (cnt1)
    );

    assign stall      = (state_q == ST_HOLD);
    assign ready_out  = ~stall;
    assign data_out0  = dataOut0_q;
    assign data_out1  = dataOut1_q;
    assign valid_out0 = validOut0_q;
    assign valid_out1 = validOut1_q;
    assign sel        = sel_q;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Directed bench for demux_lane_sched; counters built 2 bits wide so wrap is reachable.
module tb_demux_lane_sched;
    import demux_pkg::*;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              reset;
    logic              validIn;
    logic [DATA_W-1:0] dataIn;
    logic              readyOut;
    logic [1:0]        mode;
    logic              full0;
    logic              full1;
    logic [DATA_W-1:0] dataOut0;
    logic              validOut0;
    logic [DATA_W-1:0] dataOut1;
    logic              validOut1;
    logic              sel;
    logic              stall;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    int assertCount;
    int failCount;

    demux_lane_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (validIn),
        .data_in    (dataIn),
        .ready_out  (readyOut),
        .mode       (mode),
        .full0      (full0),
        .full1      (full1),
        .data_out0  (dataOut0),
        .valid_out0 (validOut0),
        .data_out1  (dataOut1),
        .valid_out1 (validOut1),
        .sel        (sel),
        .stall      (stall),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, then advance past the next rising edge so outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic v, input logic [DATA_W-1:0] d,
                                 input logic [1:0] m, input logic f0, input logic f1);
        reset   = rst;
        validIn = v;
        dataIn  = d;
        mode    = m;
        full0   = f0;
        full1   = f1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b1; validIn = 1'b0; dataIn = '0; mode = MODE_ALT; full0 = 1'b0; full1 = 1'b0;

        // Reset held three cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        end
        checkOutput("rst_valid0", 32'(validOut0), 32'd0);
        checkOutput("rst_valid1", 32'(validOut1), 32'd0);
        checkOutput("rst_data0",  32'(dataOut0),  32'd0);
        checkOutput("rst_data1",  32'(dataOut1),  32'd0);
        checkOutput("rst_sel",    32'(sel),       32'd0);
        checkOutput("rst_stall",  32'(stall),     32'd0);
        checkOutput("rst_ready",  32'(readyOut),  32'd1);
        checkOutput("rst_cnt0",   32'(cnt0),      32'd0);
        checkOutput("rst_cnt1",   32'(cnt1),      32'd0);

        // ALT back-to-back alternation
        applyStimulus(1'b0, 1'b1, 4'h1, MODE_ALT, 1'b0, 1'b0);
        checkOutput("alt_v0_1", 32'(validOut0), 32'd1);
        checkOutput("alt_d0_1", 32'(dataOut0),  32'h1);
        checkOutput("alt_v1_1", 32'(validOut1), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h2, MODE_ALT, 1'b0, 1'b0);
        checkOutput("alt_v1_2", 32'(validOut1), 32'd1);
        checkOutput("alt_d1_2", 32'(dataOut1),  32'h2);
        checkOutput("alt_sel_2", 32'(sel),      32'd1);
        checkOutput("alt_v0_2", 32'(validOut0), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h3, MODE_ALT, 1'b0, 1'b0);
        checkOutput("alt_v0_3", 32'(validOut0), 32'd1);
        checkOutput("alt_d0_3", 32'(dataOut0),  32'h3);
        applyStimulus(1'b0, 1'b1, 4'h4, MODE_ALT, 1'b0, 1'b0);
        checkOutput("alt_v1_4", 32'(validOut1), 32'd1);
        checkOutput("alt_d1_4", 32'(dataOut1),  32'h4);
        applyStimulus(1'b0, 1'b0, 4'h0, MODE_ALT, 1'b0, 1'b0);
        checkOutput("alt_idle_v0", 32'(validOut0), 32'd0);
        checkOutput("alt_idle_v1", 32'(validOut1), 32'd0);
        checkOutput("alt_hold_d0", 32'(dataOut0),  32'h3);
        checkOutput("alt_cnt0",    32'(cnt0),      32'd2);
        checkOutput("alt_cnt1",    32'(cnt1),      32'd2);

        // ALT with lane 0 full: word parks in skid, drains when full0 drops
        applyStimulus(1'b0, 1'b1, 4'h5, MODE_ALT, 1'b1, 1'b0);
        checkOutput("blk_stall", 32'(stall),     32'd1);
        checkOutput("blk_ready", 32'(readyOut),  32'd0);
        checkOutput("blk_v0",    32'(validOut0), 32'd0);
        checkOutput("blk_v1",    32'(validOut1), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, MODE_ALT, 1'b1, 1'b0);
            checkOutput("blk_wait_v0",    32'(validOut0), 32'd0);
            checkOutput("blk_wait_v1",    32'(validOut1), 32'd0);
            checkOutput("blk_wait_stall", 32'(stall),     32'd1);
        end
        applyStimulus(1'b0, 1'b0, 4'h0, MODE_ALT, 1'b0, 1'b0);
        checkOutput("drain_v0",    32'(validOut0), 32'd1);
        checkOutput("drain_d0",    32'(dataOut0),  32'h5);
        checkOutput("drain_stall", 32'(stall),     32'd0);
        checkOutput("drain_ready", 32'(readyOut),  32'd1);
        checkOutput("drain_cnt0",  32'(cnt0),      32'd3);

        // RR skips a full lane
        applyStimulus(1'b1, 1'b0, 4'h0, MODE_RR, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h9, MODE_RR, 1'b1, 1'b0);
        checkOutput("rr_v1",    32'(validOut1), 32'd1);
        checkOutput("rr_d1",    32'(dataOut1),  32'h9);
        checkOutput("rr_sel",   32'(sel),       32'd1);
        checkOutput("rr_stall", 32'(stall),     32'd0);
        checkOutput("rr_v0",    32'(validOut0), 32'd0);

        // ROUTE by MSB; ptr stays 0 so a following ALT word goes to lane 0
        applyStimulus(1'b0, 1'b1, 4'h8, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("rt_v1_8", 32'(validOut1), 32'd1);
        checkOutput("rt_d1_8", 32'(dataOut1),  32'h8);
        applyStimulus(1'b0, 1'b1, 4'h3, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("rt_v0_3", 32'(validOut0), 32'd1);
        checkOutput("rt_d0_3", 32'(dataOut0),  32'h3);
        applyStimulus(1'b0, 1'b1, 4'hF, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("rt_v1_f", 32'(validOut1), 32'd1);
        checkOutput("rt_d1_f", 32'(dataOut1),  32'hF);
        applyStimulus(1'b0, 1'b1, 4'h0, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("rt_v0_0", 32'(validOut0), 32'd1);
        checkOutput("rt_d0_0", 32'(dataOut0),  32'h0);
        checkOutput("rt_v1_0", 32'(validOut1), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h7, MODE_ALT, 1'b0, 1'b0);
        checkOutput("rt_ptr_v0", 32'(validOut0), 32'd1);
        checkOutput("rt_ptr_d0", 32'(dataOut0),  32'h7);

        // Counter wrap on lane 0, then reset while holding a blocked word
        applyStimulus(1'b1, 1'b0, 4'h0, MODE_ROUTE, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h1, MODE_ROUTE, 1'b0, 1'b0);
            checkOutput("wrap_cnt0", 32'(cnt0), 32'(i % 4));
        end
        applyStimulus(1'b0, 1'b1, 4'h2, MODE_ROUTE, 1'b1, 1'b0);
        checkOutput("hold_stall", 32'(stall), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h0, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("rsthold_stall", 32'(stall),     32'd0);
        checkOutput("rsthold_ready", 32'(readyOut),  32'd1);
        checkOutput("rsthold_cnt0",  32'(cnt0),      32'd0);
        checkOutput("rsthold_v0",    32'(validOut0), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, MODE_ROUTE, 1'b0, 1'b0);
        checkOutput("postrst_v0",   32'(validOut0), 32'd0);
        checkOutput("postrst_v1",   32'(validOut1), 32'd0);
        checkOutput("postrst_cnt0", 32'(cnt0),      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
